// File: rtl/input_block_vc.sv
//==============================================================================
// Module      : input_block_vc (with router_pkg)
// Description : Per-port VC router input buffer. One FIFO per virtual channel,
//               per-VC packet-format FSM, registered dequeue path with a
//               one-cycle credit pulse back to the upstream output block.
// Options     : IB_ERR_FLAGS_EN - when defined, err_r holds sticky
//               {format, underflow, overflow} flags; otherwise tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package router_pkg;
  localparam int NUM_VCS        = 2;
  localparam int CREDITS_PER_VC = 4;
  localparam int VCID_W         = $clog2(NUM_VCS);
  localparam int DATA_W         = 32;

  typedef enum logic [2:0] {I = 3'd0, H = 3'd1, B = 3'd2, T = 3'd3, HT = 3'd4} ftype_t;
  typedef enum logic [2:0] {N = 3'd0, E = 3'd1, S = 3'd2, W = 3'd3, L = 3'd4} dir_t;

  typedef struct packed {
    ftype_t              ftype;
    logic [VCID_W-1:0]   fvcid;
  } head_t;

  typedef struct packed {
    head_t               head;
    logic [DATA_W-1:0]   data;
  } channel_t;
endpackage

module input_block_vc #(
  parameter int               NUM_VCS    = router_pkg::NUM_VCS,
  parameter int               BUF_DEPTH  = router_pkg::CREDITS_PER_VC,
  parameter router_pkg::dir_t LOCAL_PORT = router_pkg::W
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  router_pkg::channel_t         flitin,
  input  logic                         rd_en,
  input  logic [$clog2(NUM_VCS)-1:0]   rd_vcid,
  output router_pkg::channel_t         front_flit [NUM_VCS],
  output logic [NUM_VCS-1:0]           vc_empty,
  output logic [NUM_VCS-1:0]           vc_active_r,
  output router_pkg::channel_t         flitout,
  output logic [NUM_VCS-1:0]           creditout,
  output logic [2:0]                   err_r
);
  import router_pkg::*;

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int RD_W  = $clog2(NUM_VCS);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} pkt_state_t;

  logic               wr_valid;
  logic [NUM_VCS-1:0] pop_vc;
  logic [NUM_VCS-1:0] ovf_vc;
  logic [NUM_VCS-1:0] fmt_vc;
  logic               underflow_ev;

  assign wr_valid = (flitin.head.ftype != I);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    channel_t         mem_q [BUF_DEPTH];
    channel_t         head_flit;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pkt_state_t       state_q, state_d;
    logic             wr_hit, full, empty, push, pop, fmt_bad;

    assign head_flit = mem_q[rd_ptr_q];

    // FIFO pointer/occupancy update and packet FSM next state for this VC.
    always_comb begin
      wr_hit   = wr_valid && (flitin.head.fvcid == VCID_W'(v));
      empty    = (cnt_q == '0);
      full     = (cnt_q == CNT_W'(BUF_DEPTH));
      push     = wr_hit && !full;
      pop      = rd_en && (rd_vcid == RD_W'(v)) && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      state_d  = state_q;
      fmt_bad  = 1'b0;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
      if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
      // Malformed sequences are still forwarded; only the flag is raised.
      if (pop) begin
        case (state_q)
          ST_IDLE: begin
            if (head_flit.head.ftype == H)        state_d = ST_ACTIVE;
            else if (head_flit.head.ftype != HT)  fmt_bad = 1'b1;
          end
          ST_ACTIVE: begin
            if (head_flit.head.ftype == T)        state_d = ST_IDLE;
            else if (head_flit.head.ftype != B)   fmt_bad = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // Pointer, occupancy and packet-state registers; reset flushes the VC.
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        state_q  <= ST_IDLE;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        state_q  <= state_d;
      end
    end

    // Flit storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= flitin;
    end

    assign front_flit[v]  = empty ? '0 : head_flit;
    assign vc_empty[v]    = empty;
    assign vc_active_r[v] = (state_q == ST_ACTIVE);
    assign pop_vc[v]      = pop;
    assign ovf_vc[v]      = wr_hit && full;
    assign fmt_vc[v]      = fmt_bad;
  end

  channel_t           flitout_q, flitout_d;
  logic [NUM_VCS-1:0] creditout_q, creditout_d;

  // Select the dequeued flit and the credit for the output registers.
  always_comb begin
    flitout_d    = '0;
    creditout_d  = pop_vc;
    underflow_ev = rd_en && vc_empty[rd_vcid];
    if (|pop_vc) flitout_d = front_flit[rd_vcid];
  end

  // Registered crossbar flit and credit pulse, aligned in the same cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      flitout_q   <= '0;
      creditout_q <= '0;
    end else begin
      flitout_q   <= flitout_d;
      creditout_q <= creditout_d;
    end
  end

  assign flitout   = flitout_q;
  assign creditout = creditout_q;

`ifdef IB_ERR_FLAGS_EN
  logic [2:0] err_q, err_d;

  // Sticky error flags {format, underflow, overflow}, cleared only by reset.
  always_comb begin
    err_d = err_q | {|fmt_vc, underflow_ev, |ovf_vc};
  end

  // Error flag register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) err_q <= '0;
    else         err_q <= err_d;
  end

  assign err_r = err_q;
`else
  assign err_r = 3'b000;
`endif

`ifndef SYNTHESIS
  // Simulation reports of protocol violations seen at the link or allocator.
  always_ff @(posedge clk) begin
    if (arst_n) begin
      if (|ovf_vc)
        $warning("input_block_vc[%s]: overflow, flit dropped on full VC %0d",
                 LOCAL_PORT.name(), flitin.head.fvcid);
      if (underflow_ev)
        $warning("input_block_vc[%s]: underflow, read of empty VC %0d",
                 LOCAL_PORT.name(), rd_vcid);
      if (|fmt_vc)
        $warning("input_block_vc[%s]: packet format violation on VC %0d",
                 LOCAL_PORT.name(), rd_vcid);
    end
  end
`endif

endmodule

`default_nettype wire
